etapa_decod_imm: RTL

ETAPA_DECOD_IMM -- requirements
Module: etapa_decod_imm

---
 rtl/etapa_decod_imm.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/etapa_decod_imm.sv
// rtl/etapa_decod_imm.sv - two-entry skid stage that decodes the instruction format and tracks illegal opcodes
module etapa_decod_imm (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        Inst_valida,
   input  logic [31:0] Instruccion,
   input  logic [31:0] PC_in,
   input  logic        Listo_sig,
   input  logic        Stall,
   input  logic        Flush,
   output logic        Listo,
   output logic        Salida_valida,
   output logic [31:0] Inst_reg,
   output logic [31:0] PC_reg,
   output logic [4:0]  Campo_0,
   output logic [4:0]  Campo_1,
   output logic        Control_mux,
   output logic [2:0]  Tipo,
   output logic        Inst_ilegal,
   output logic [7:0]  Cont_ilegales
);

   // Encoding chosen so bit 0 means "output register full" and bit 1 means "skid full"
   localparam logic [1:0] VACIO = 2'b00;
   localparam logic [1:0] UNO   = 2'b01;
   localparam logic [1:0] DOS   = 2'b11;

   logic [1:0]  state;
   logic [1:0]  state_next;
   logic        accept;
   logic        consume;

   logic [2:0]  dec_tipo;
   logic        dec_ilegal;
   logic        dec_cm;

   logic [31:0] skid_inst;
   logic [31:0] skid_pc;
   logic [2:0]  skid_tipo;
   logic        skid_ilegal;
   logic        skid_cm;

   assign accept  = Inst_valida & Listo;
   assign consume = Salida_valida & Listo_sig & ~Stall;

   // Format decode of the incoming word; the result is captured alongside it
   always_comb begin
      dec_tipo   = 3'd7;
      dec_ilegal = 1'b0;
      case (Instruccion[6:0])
         7'b0110011:                         dec_tipo = 3'd0;
         7'b0010011, 7'b0000011, 7'b1100111: dec_tipo = 3'd1;
         7'b0100011:                         dec_tipo = 3'd2;
         7'b1100011:                         dec_tipo = 3'd3;
         7'b0110111, 7'b0010111:             dec_tipo = 3'd4;
         7'b1101111:                         dec_tipo = 3'd5;
         default: begin
            dec_tipo   = 3'd7;
            dec_ilegal = 1'b1;
         end
      endcase
      dec_cm = (dec_tipo == 3'd2) || (dec_tipo == 3'd3);
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= VACIO;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: flush overrides everything, otherwise fill/drain the two slots
   always_comb begin
      state_next = state;
      if (Flush) begin
         state_next = VACIO;
      end else begin
         case (state)
            VACIO: if (accept) state_next = UNO;
            UNO: begin
               if (accept && !consume) begin
                  state_next = DOS;
               end else if (!accept && consume) begin
                  state_next = VACIO;
               end
            end
            DOS:     if (consume) state_next = UNO;
            default: state_next = VACIO;
         endcase
      end
   end

   // Handshake outputs depend only on the state flops
   always_comb begin
      Salida_valida = state[0];
      Listo         = ~state[1];
   end

   // Output and skid registers; a flushed cycle loads nothing
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         Inst_reg    <= '0;
         PC_reg      <= '0;
         Tipo        <= '0;
         Inst_ilegal <= 1'b0;
         Control_mux <= 1'b0;
         skid_inst   <= '0;
         skid_pc     <= '0;
         skid_tipo   <= '0;
         skid_ilegal <= 1'b0;
         skid_cm     <= 1'b0;
      end else if (!Flush) begin
         if (accept && (state == VACIO || consume)) begin
            Inst_reg    <= Instruccion;
            PC_reg      <= PC_in;
            Tipo        <= dec_tipo;
            Inst_ilegal <= dec_ilegal;
            Control_mux <= dec_cm;
         end else if (accept && state == UNO) begin
            skid_inst   <= Instruccion;
            skid_pc     <= PC_in;
            skid_tipo   <= dec_tipo;
            skid_ilegal <= dec_ilegal;
            skid_cm     <= dec_cm;
         end else if (state == DOS && consume) begin
            Inst_reg    <= skid_inst;
            PC_reg      <= skid_pc;
            Tipo        <= skid_tipo;
            Inst_ilegal <= skid_ilegal;
            Control_mux <= skid_cm;
         end
      end
   end

   // Saturating illegal-opcode counter; survives flush, only reset clears it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         Cont_ilegales <= '0;
      end else if (accept && dec_ilegal && !Flush && Cont_ilegales != 8'hFF) begin
         Cont_ilegales <= Cont_ilegales + 8'd1;
      end
   end

   assign Campo_0 = Inst_reg[24:20];
   assign Campo_1 = Inst_reg[11:7];

endmodule
